// File: rtl/uart_rx_autobaud_pkg.sv
// Shared types, constants and helpers for the auto-baud UART receiver.
package uart_pkg;

    typedef enum logic [3:0] {
        CAL_IDLE,
        CAL_MEAS,
        CAL_STOP,
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        BRK
    } state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Maps the PARITY string parameter onto one of the PARITY_* constants.
    function automatic int parity_mode(input logic [31:0] name);
        if (name == "EVEN") return PARITY_EVEN;
        if (name == {8'h00, "ODD"}) return PARITY_ODD;
        return PARITY_NONE;
    endfunction

    // True when the received parity bit disagrees with the data under the given mode.
    function automatic logic parity_error(input int mode, input logic [7:0] data, input logic par_bit);
        logic w_ones_odd;
        w_ones_odd = ^{data, par_bit};
        return (mode == PARITY_ODD) ? ~w_ones_odd : w_ones_odd;
    endfunction

endpackage

// File: rtl/uart_rx_autobaud_if.sv
// Received-frame stream: data with status flags and a valid/ready handshake.
interface uart_rx_autobaud_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic                 parity_err_o;
    logic                 frame_err_o;
    logic                 overrun_o;

    modport master (
        output rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o,
        input  rx_ready_i
    );

    modport slave (
        input  rx_data_o, rx_valid_o, parity_err_o, frame_err_o, overrun_o,
        output rx_ready_i
    );
endinterface

// File: rtl/uart_rx_autobaud_sync_vote.sv
// 2-FF synchroniser, 3-deep history with majority vote, and edge strobes.
module uart_rx_sync_vote (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_sample,
    output logic o_sync,
    output logic o_fall,
    output logic o_rise
);
    logic       r_sync1;
    logic       r_sync2;
    logic [2:0] r_hist;

    // Synchronise the pin and keep a short history of the synchronised bit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= '1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
            r_hist  <= {r_hist[1:0], r_sync2};
        end
    end

    // Edges compare the synchronised bit with its previous value (hist[0]).
    assign o_sync   = r_sync2;
    assign o_fall   = r_hist[0] & ~r_sync2;
    assign o_rise   = ~r_hist[0] & r_sync2;
    assign o_sample = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);
endmodule

// File: rtl/uart_rx_autobaud.sv
// Auto-baud UART receiver: calibrates on a 0x55 sync byte, then receives
// frames into a one-entry buffer with parity/framing/overrun reporting.
module uart_rx_autobaud
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter     PARITY     = "NONE",
    parameter int CNT_WIDTH  = 32,
    parameter int MIN_PERIOD = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rx_i,
    input  logic                   relock_i,
    uart_rx_autobaud_if.master     rx_if,
    output logic                   locked_o,
    output logic [CNT_WIDTH-4:0]   bitperiod_o
);
    localparam int             PW        = CNT_WIDTH - 3;
    localparam int             PAR_MODE  = parity_mode(PARITY);
    localparam logic [PW-1:0]  MIN_P     = PW'(MIN_PERIOD);
    localparam logic [7:0]     SYNC_BYTE = 8'h55;

    logic w_sample, w_sync, w_fall, w_rise;

    uart_rx_sync_vote u_sync_vote (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_rx     (rx_i),
        .o_sample (w_sample),
        .o_sync   (w_sync),
        .o_fall   (w_fall),
        .o_rise   (w_rise)
    );

    state_t                 r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc, w_full, w_half;
    logic [2:0]             r_falls, w_falls_nxt, r_bitidx, w_bitidx_nxt;
    logic [PW-1:0]          r_meas_p, w_meas_p_nxt, r_bitperiod, w_bitperiod_nxt, w_p;
    logic                   r_locked, w_locked_nxt;
    logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
    logic                   r_perr, w_perr_nxt;
    logic                   w_push, w_push_perr, w_push_ferr;
    logic [DATA_BITS-1:0]   w_push_data;
    logic [DATA_BITS-1:0]   r_buf_data;
    logic                   r_buf_valid, r_buf_perr, r_buf_ferr, r_overrun, w_accept;

    // The measurement includes the cycle of the closing edge, so 8 bit-times give 8*P.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_p       = w_cnt_inc[CNT_WIDTH-1:3];
    assign w_full    = {3'b000, r_bitperiod};
    assign w_half    = w_full >> 1;
    assign w_accept  = r_buf_valid & rx_if.rx_ready_i;

    // FSM and datapath state registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= CAL_IDLE;
            r_cnt       <= '0;
            r_falls     <= '0;
            r_bitidx    <= '0;
            r_meas_p    <= '0;
            r_bitperiod <= '0;
            r_locked    <= 1'b0;
            r_shift     <= '0;
            r_perr      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_falls     <= w_falls_nxt;
            r_bitidx    <= w_bitidx_nxt;
            r_meas_p    <= w_meas_p_nxt;
            r_bitperiod <= w_bitperiod_nxt;
            r_locked    <= w_locked_nxt;
            r_shift     <= w_shift_nxt;
            r_perr      <= w_perr_nxt;
        end
    end

    // Next-state and datapath decisions; relock overrides every state action.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_falls_nxt     = r_falls;
        w_bitidx_nxt    = r_bitidx;
        w_meas_p_nxt    = r_meas_p;
        w_bitperiod_nxt = r_bitperiod;
        w_locked_nxt    = r_locked;
        w_shift_nxt     = r_shift;
        w_perr_nxt      = r_perr;
        w_push          = 1'b0;
        w_push_data     = r_shift;
        w_push_perr     = 1'b0;
        w_push_ferr     = 1'b0;
        if (relock_i) begin
            w_state_nxt     = CAL_IDLE;
            w_cnt_nxt       = '0;
            w_locked_nxt    = 1'b0;
            w_bitperiod_nxt = '0;
        end else begin
            case (r_state)
                CAL_IDLE: if (w_fall) begin
                    w_cnt_nxt   = '0;
                    w_falls_nxt = '0;
                    w_state_nxt = CAL_MEAS;
                end
                CAL_MEAS: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == '1) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = CAL_IDLE;
                    end else if (w_fall) begin
                        if (r_falls == 3'd3) begin
                            w_meas_p_nxt = w_p;
                            w_state_nxt  = (w_p < MIN_P) ? CAL_IDLE : CAL_STOP;
                        end else begin
                            w_falls_nxt = r_falls + 1'b1;
                        end
                    end
                end
                CAL_STOP: if (w_rise) begin
                    w_bitperiod_nxt = r_meas_p;
                    w_locked_nxt    = 1'b1;
                    w_push          = 1'b1;
                    w_push_data     = SYNC_BYTE[DATA_BITS-1:0];
                    w_state_nxt     = IDLE;
                end
                IDLE: if (w_fall) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = START;
                end
                START: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == w_half) begin
                        if (w_sample) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_cnt_nxt    = '0;
                            w_bitidx_nxt = '0;
                            w_perr_nxt   = 1'b0;
                            w_state_nxt  = DATA;
                        end
                    end
                end
                DATA: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == w_full) begin
                        w_shift_nxt  = {w_sample, r_shift[DATA_BITS-1:1]};
                        w_cnt_nxt    = '0;
                        w_bitidx_nxt = r_bitidx + 1'b1;
                        if (r_bitidx == 3'(DATA_BITS - 1))
                            w_state_nxt = (PAR_MODE != PARITY_NONE) ? PAR : STOP;
                    end
                end
                PAR: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == w_full) begin
                        w_perr_nxt  = parity_error(PAR_MODE, 8'(r_shift), w_sample);
                        w_cnt_nxt   = '0;
                        w_state_nxt = STOP;
                    end
                end
                STOP: begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == w_full) begin
                        w_push      = 1'b1;
                        w_push_perr = r_perr;
                        w_push_ferr = ~w_sample;
                        w_cnt_nxt   = '0;
                        w_state_nxt = w_sample ? IDLE : BRK;
                    end
                end
                BRK: if (w_sync) w_state_nxt = IDLE;
                default: w_state_nxt = CAL_IDLE;
            endcase
        end
    end

    // One-entry output buffer; a push into a full, unaccepted buffer is dropped.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_buf_data  <= '0;
            r_buf_valid <= 1'b0;
            r_buf_perr  <= 1'b0;
            r_buf_ferr  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_push) begin
                if (!r_buf_valid || w_accept) begin
                    r_buf_data  <= w_push_data;
                    r_buf_perr  <= w_push_perr;
                    r_buf_ferr  <= w_push_ferr;
                    r_buf_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_accept) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data_o    = r_buf_data;
    assign rx_if.rx_valid_o   = r_buf_valid;
    assign rx_if.parity_err_o = r_buf_perr;
    assign rx_if.frame_err_o  = r_buf_ferr;
    assign rx_if.overrun_o    = r_overrun;
    assign locked_o           = r_locked;
    assign bitperiod_o        = r_bitperiod;
endmodule
